// File: rtl/thiele_hash_pkg.sv
// Shared constants and state encoding for the snapshot hashing engine and its
// xorshift mixer.
package thiele_hash_pkg;
    localparam int unsigned XS_SHL_A   = 13;
    localparam int unsigned XS_SHR_B   = 17;
    localparam int unsigned XS_SHL_C   = 5;
    localparam int unsigned HASH_LANES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } hash_state_t;
endpackage

// File: rtl/state_hash_engine_if.sv
// Snapshot stream in, digest out. The engine takes the slave side; the core and
// the reporter drive the master side.
interface state_hash_engine_if #(
    parameter int NUM_WORDS = 8,
    parameter int CNT_W     = $clog2(NUM_WORDS)
) ();
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [32*NUM_WORDS-1:0] digest;
    logic [CNT_W:0]          words_seen;
    logic                    frame_err;
    logic                    busy;

    modport slave (
        input  start, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, digest, words_seen, frame_err, busy
    );

    modport master (
        output start, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, digest, words_seen, frame_err, busy
    );
endinterface

// File: rtl/xorshift32_mix.sv
// Pure combinational xorshift32 round (<<13, >>17, <<5); shared with the
// reporter's self-check so both sides hash identically.
module xorshift32_mix
    import thiele_hash_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);
    logic [31:0] step_a;
    logic [31:0] step_b;

    always_comb begin
        step_a = din ^ (din << XS_SHL_A);
        step_b = step_a ^ (step_a >> XS_SHR_B);
        dout   = step_b ^ (step_b << XS_SHL_C);
    end
endmodule

// File: rtl/state_hash_engine.sv
// Collects NUM_WORDS snapshot words, mixes word k into digest lane k and holds
// the digest until the reporter takes it.
module state_hash_engine
    import thiele_hash_pkg::*;
#(
    parameter int NUM_WORDS = HASH_LANES,
    parameter int CNT_W     = $clog2(NUM_WORDS)
) (
    input  logic clk,
    input  logic rst_n,
    state_hash_engine_if.slave bus
);
    hash_state_t state, state_nxt;

    logic [CNT_W-1:0]        idx;
    logic [CNT_W:0]          words_seen;
    logic                    frame_err;
    logic [31:0]             lane_q [NUM_WORDS];
    logic [31:0]             mixed;
    logic [32*NUM_WORDS-1:0] digest_w;
    logic                    in_ready;
    logic                    xfer;
    logic                    last_idx;

    xorshift32_mix u_mix (
        .din  (bus.in_data),
        .dout (mixed)
    );

    assign xfer     = bus.in_valid & in_ready;
    assign last_idx = (idx == CNT_W'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)            state_nxt = LOAD;
            LOAD:    if (xfer && last_idx)     state_nxt = DONE;
            DONE:    if (bus.out_ready)        state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend on registered state only.
    always_comb begin
        in_ready      = (state == LOAD);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && bus.start)) begin
            idx        <= '0;
            words_seen <= '0;
            frame_err  <= 1'b0;
            for (int k = 0; k < NUM_WORDS; k++) lane_q[k] <= '0;
        end else if (xfer) begin
            lane_q[idx] <= mixed;
            words_seen  <= words_seen + (CNT_W+1)'(1);
            // idx parks on the final lane instead of wrapping.
            if (!last_idx) idx <= idx + CNT_W'(1);
            if (bus.in_last != last_idx) frame_err <= 1'b1;
        end
    end

    always_comb begin
        digest_w = '0;
        for (int k = 0; k < NUM_WORDS; k++) digest_w[k*32 +: 32] = lane_q[k];
    end

    assign bus.in_ready   = in_ready;
    assign bus.digest     = digest_w;
    assign bus.words_seen = words_seen;
    assign bus.frame_err  = frame_err;
endmodule
